multdiv_unit: RTL
=================

// Module: multdiv_unit
// PURPOSE
//  Iterative signed 32-bit multiply/divide unit in the execute stage, beside ALU1.
//  It takes operands from the D/X register outputs (regA_x, regB_x) when the D/X ALU
//  opcode is mult (00110) or div (00111).
//  Its busy output stalls PC, F/D and D/X.
//  Its result and exception feed the X/M register: exception sets overflow, so the
//  write-back stage loads rstatus.
// PARAMETERS
//  WIDTH   32  operand/result width; the iteration count equals WIDTH
//  CNT_W    6  counter width; must hold values 0..WIDTH
// PORTS
//  clock        in   1      rising-edge clock
//  reset        in   1      asynchronous, active-low; clears all state
//  ctrl_MULT    in   1      start-multiply request, sampled on the edge
//  ctrl_DIV     in   1      start-divide request, sampled on the edge
//  operand_A    in   WIDTH  multiplicand / dividend, signed
//  operand_B    in   WIDTH  multiplier / divisor, signed
//  result       out  WIDTH  product low word / quotient
//  exception    out  1      overflow or divide-by-zero; valid with data_ready
//  data_ready   out  1      one-cycle pulse; result and exception are valid
//  busy         out  1      operation in flight; pipeline stall request
// BEHAVIOUR
//  - Reset values: result=0, exception=0, data_ready=0, busy=0, state=IDLE, counter=0.
//  - States:
//    - IDLE:
//      - Sampling ctrl_MULT=1 latches A/B and goes to MULT.
//      - Otherwise, sampling ctrl_DIV=1 latches A/B and goes to DIV.
//      - If both are 1, multiply wins.
//    - MULT and DIV: one iteration per cycle, counter 0..WIDTH-1.
//      - At counter==WIDTH-1 the unit goes to DONE.
//    - DONE: data_ready=1 for exactly one cycle, then back to IDLE.
//  - busy = (state != IDLE). It is high from the cycle after the start edge through
//    the DONE cycle.
//  - Latency: a start sampled at edge E0 gives data_ready high in the cycle following
//    edge E0+WIDTH (33 cycles for WIDTH=32).
//  - Starts: ctrl_MULT and ctrl_DIV are ignored while busy. No queueing.
//    A request on the DONE cycle is dropped.
//  - Result hold: result and exception hold their values after DONE until the next
//    operation reaches DONE.
//  - Multiply (radix-2 Booth):
//    - 2*WIDTH+1-bit product register; arithmetic right shift.
//    - result = product[WIDTH-1:0].
//    - exception=1 when product[2*WIDTH-1:WIDTH-1] is not all-equal, i.e. the product
//      does not fit in WIDTH signed bits.
//  - Divide (restoring, on magnitudes):
//    - Quotient sign = sign(A) XOR sign(B); quotient truncates toward zero.
//    - The remainder is discarded.
//    - B==0: result=0, exception=1. Still takes the full WIDTH iterations
//      (see CONFIGURATION).
//    - A==0x80000000 with B==0xFFFFFFFF: result=0x80000000, exception=1.
//  - Reset mid-operation: the unit aborts to IDLE, busy drops asynchronously, no
//    data_ready is produced, and result clears to 0.
// CONFIGURATION
//  MULTDIV_EARLY_ZERO_EN
//  - Defined:
//    - A start whose result is known to be zero skips the iterations: IDLE goes
//      straight to DONE.
//    - This applies to a multiply with A==0 or B==0, a divide with A==0, and a divide
//      with B==0.
//    - data_ready is high in the cycle after the start edge and busy is high for that
//      one cycle.
//    - result=0. exception=1 only for B==0 on a divide.
//  - Undefined: every operation takes the full WIDTH+1-cycle latency.
// TESTING
//  1. Multiply 7 x -3: ctrl_MULT pulse with A=7, B=0xFFFFFFFD -> busy for 33 cycles;
//     data_ready pulse on cycle 33; result=0xFFFFFFEB, exception=0.
//  2. Multiply overflow: A=0x00010000, B=0x00010000 -> result=0x00000000, exception=1.
//  3. Divide -17 / 5: A=0xFFFFFFEF, B=5 -> result=0xFFFFFFFD (-3), exception=0.
//  4. Divide by zero: A=42, B=0 -> result=0, exception=1.
//     Latency is 33 cycles without the macro and 1 cycle with it.
//  5. Simultaneous and late starts:
//     - ctrl_MULT=ctrl_DIV=1 with A=6, B=3 -> result=18 (multiply).
//     - A ctrl_DIV pulse at cycle 10 of a busy operation is ignored: exactly one
//       data_ready occurs.
//  6. Reset mid-operation: reset low at cycle 12 of a divide -> busy=0 and result=0
//     immediately, no data_ready. A new multiply 2x2 after release gives result=4.

Source files
------------

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit; WIDTH cycles per op.
// Optional MULTDIV_EARLY_ZERO_EN: operations with a known-zero result finish in one cycle.
module multdiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] operand_A,
   input  logic [WIDTH-1:0] operand_B,
   output logic [WIDTH-1:0] result,
   output logic             exception,
   output logic             data_ready,
   output logic             busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MULT = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
      return v[WIDTH-1] ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag, input logic neg);
      return neg ? (~mag + 1'b1) : mag;
   endfunction

   logic [1:0]              state;
   logic [CNT_W-1:0]        count;
   logic signed [WIDTH-1:0] mcand;
   logic [WIDTH-1:0]        divisor;
   logic [2*WIDTH:0]        prod;
   logic [2*WIDTH:0]        prod_next;
   logic [WIDTH-1:0]        rem, rem_next;
   logic [WIDTH-1:0]        quo, quo_next;
   logic                    neg_q, div_zero, div_ovf;
   logic signed [WIDTH:0]   upper_ext, addend, upper_sum;
   logic [WIDTH:0]          rem_sh, rem_diff;
   logic [WIDTH:0]          mult_chk;
   logic                    mult_ovf;
   logic [WIDTH-1:0]        div_res;
   logic                    div_exc;
   logic                    early_zero;

`ifdef MULTDIV_EARLY_ZERO_EN
   assign early_zero = (operand_A == '0) || (operand_B == '0);
`else
   assign early_zero = 1'b0;
`endif

   // Booth step: the upper half is summed one bit wider so the shift keeps the true sign.
   always_comb begin
      upper_ext = {prod[2*WIDTH], prod[2*WIDTH:WIDTH+1]};
      addend    = {mcand[WIDTH-1], mcand};
      case (prod[1:0])
         2'b01:   upper_sum = upper_ext + addend;
         2'b10:   upper_sum = upper_ext - addend;
         default: upper_sum = upper_ext;
      endcase
      prod_next = {upper_sum, prod[WIDTH:1]};
      mult_chk  = prod_next[2*WIDTH:WIDTH];
      mult_ovf  = !((&mult_chk) || !(|mult_chk));
   end

   // Restoring divide step on magnitudes; a clear top bit of the difference means no borrow.
   always_comb begin
      rem_sh   = {rem, quo[WIDTH-1]};
      rem_diff = rem_sh - {1'b0, divisor};
      rem_next = rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], ~rem_diff[WIDTH]};
      div_res  = div_zero ? '0 : apply_sign(quo_next, neg_q);
      div_exc  = div_zero | div_ovf;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         count     <= '0;
         result    <= '0;
         exception <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               count <= '0;
               if (ctrl_MULT || ctrl_DIV) begin
                  if (early_zero) begin
                     state     <= S_DONE;
                     result    <= '0;
                     exception <= !ctrl_MULT && (operand_B == '0);
                  end else begin
                     state <= ctrl_MULT ? S_MULT : S_DIV;
                  end
               end
            end
            S_MULT: begin
               count <= count + 1'b1;
               if (count == CNT_LAST) begin
                  state     <= S_DONE;
                  result    <= prod_next[WIDTH:1];
                  exception <= mult_ovf;
               end
            end
            S_DIV: begin
               count <= count + 1'b1;
               if (count == CNT_LAST) begin
                  state     <= S_DONE;
                  result    <= div_res;
                  exception <= div_exc;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Operand registers reload every idle cycle, so they need no reset.
   always_ff @(posedge clock) begin
      if (state == S_IDLE) begin
         mcand    <= operand_A;
         prod     <= {{WIDTH{1'b0}}, operand_B, 1'b0};
         divisor  <= magnitude(operand_B);
         rem      <= '0;
         quo      <= magnitude(operand_A);
         neg_q    <= operand_A[WIDTH-1] ^ operand_B[WIDTH-1];
         div_zero <= (operand_B == '0);
         div_ovf  <= (operand_A == {1'b1, {(WIDTH-1){1'b0}}}) && (operand_B == '1);
      end else if (state == S_MULT) begin
         prod <= prod_next;
      end else if (state == S_DIV) begin
         rem <= rem_next;
         quo <= quo_next;
      end
   end

   assign data_ready = (state == S_DONE);
   assign busy       = (state != S_IDLE);

endmodule
